// File: rtl/calc_sequencer.sv
// calc_sequencer: operand-entry and execution controller that drives an external multi-cycle ALU.
// Optional EXEC watchdog with an ERROR state is compiled in when CALC_TIMEOUT_EN is defined.

module calc_sequencer #(
    parameter int WIDTH    = 8,
    parameter int OP_W     = 4,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [OP_W-1:0]  OpIn,
    input  logic             Enter,
    input  logic             Clear,
    input  logic             ChainMode,
    output logic             AluStart,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [OP_W-1:0]  AluOp,
    input  logic             AluDone,
    input  logic [WIDTH-1:0] AluResult,
    input  logic [2:0]       AluFlags,
    output logic [WIDTH-1:0] Result,
    output logic [2:0]       Flags,
    output logic [3:0]       Stage,
    output logic [CNT_W-1:0] OpCount,
    output logic             Error,
    output logic [2:0]       DbgState
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HAVE_A = 3'd1,
        S_HAVE_B = 3'd2,
        S_EXEC   = 3'd3,
        S_RESULT = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_enter_s1, r_enter_s2;
    logic              r_clear_s1, r_clear_s2, r_clear_s3;
    logic [DB_W-1:0]   r_deb_cnt;
    logic              r_enter_pulse;
    logic              w_clear_pulse;
    logic [WIDTH-1:0]  r_alu_a, r_alu_b, r_result;
    logic [OP_W-1:0]   r_alu_op;
    logic [2:0]        r_flags;
    logic [CNT_W-1:0]  r_op_count;
    logic              r_alu_start;
    logic              w_load_a, w_load_b, w_launch, w_complete;
    logic [WIDTH-1:0]  w_a_src;
    logic [3:0]        w_stage;

    // Enter pulse is registered so it lands exactly DEBOUNCE cycles after sync Enter rises.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_enter_s1    <= 1'b0;
            r_enter_s2    <= 1'b0;
            r_clear_s1    <= 1'b0;
            r_clear_s2    <= 1'b0;
            r_clear_s3    <= 1'b0;
            r_deb_cnt     <= '0;
            r_enter_pulse <= 1'b0;
        end else begin
            r_enter_s1    <= Enter;
            r_enter_s2    <= r_enter_s1;
            r_clear_s1    <= Clear;
            r_clear_s2    <= r_clear_s1;
            r_clear_s3    <= r_clear_s2;
            r_enter_pulse <= r_enter_s2 && (r_deb_cnt == DB_W'(DEBOUNCE - 1));
            if (!r_enter_s2)
                r_deb_cnt <= '0;
            else if (r_deb_cnt != DB_W'(DEBOUNCE))
                r_deb_cnt <= r_deb_cnt + DB_W'(1);
        end
    end

    assign w_clear_pulse = r_clear_s2 && !r_clear_s3;

`ifdef CALC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clock) begin
        if (reset || w_launch)
            r_to_cnt <= '0;
        else if (r_state == S_EXEC && r_to_cnt != TO_W'(TIMEOUT))
            r_to_cnt <= r_to_cnt + TO_W'(1);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // AluStart/AluDone are one-cycle pulses: start is issued once per launch, and done is
    // honoured only in EXEC and never in the start cycle itself (the ALU replies 1+ cycles later).
    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_launch    = 1'b0;
        w_complete  = 1'b0;
        w_a_src     = DataIn;
        if (w_clear_pulse) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (r_enter_pulse) begin
                    w_load_a    = 1'b1;
                    w_state_nxt = S_HAVE_A;
                end
                S_HAVE_A: if (r_enter_pulse) begin
                    w_load_b    = 1'b1;
                    w_state_nxt = S_HAVE_B;
                end
                S_HAVE_B: if (r_enter_pulse) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
                S_EXEC: begin
                    if (AluDone && !r_alu_start) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_RESULT;
                    end
`ifdef CALC_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        w_state_nxt = S_ERROR;
                    end
`endif
                end
                S_RESULT: if (r_enter_pulse) begin
                    w_load_a    = 1'b1;
                    w_a_src     = ChainMode ? r_result : DataIn;
                    w_state_nxt = S_HAVE_A;
                end
`ifdef CALC_TIMEOUT_EN
                S_ERROR: w_state_nxt = S_ERROR;
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_op_count  <= '0;
            r_alu_start <= 1'b0;
        end else begin
            r_alu_start <= w_launch;
            if (w_clear_pulse) begin
                r_alu_a  <= '0;
                r_alu_b  <= '0;
                r_alu_op <= '0;
                r_result <= '0;
                r_flags  <= '0;
            end else begin
                if (w_load_a)
                    r_alu_a <= w_a_src;
                if (w_load_b)
                    r_alu_b <= DataIn;
                if (w_launch)
                    r_alu_op <= OpIn;
                if (w_complete) begin
                    r_result <= AluResult;
                    r_flags  <= AluFlags;
                    if (r_op_count != {CNT_W{1'b1}})
                        r_op_count <= r_op_count + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_stage = 4'b0001;
        case (r_state)
            S_IDLE:   w_stage = 4'b0001;
            S_HAVE_A: w_stage = 4'b0011;
            S_HAVE_B: w_stage = 4'b0111;
            S_EXEC:   w_stage = 4'b0111;
            S_RESULT: w_stage = 4'b1111;
            S_ERROR:  w_stage = 4'b1001;
            default:  w_stage = 4'b0001;
        endcase
    end

`ifdef CALC_TIMEOUT_EN
    assign Error = (r_state == S_ERROR);
`else
    assign Error = 1'b0;
`endif

    assign AluStart = r_alu_start;
    assign AluA     = r_alu_a;
    assign AluB     = r_alu_b;
    assign AluOp    = r_alu_op;
    assign Result   = r_result;
    assign Flags    = r_flags;
    assign OpCount  = r_op_count;
    assign Stage    = w_stage;
    assign DbgState = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: vector table, hand-written corner sequences and a
// randomized phase checked against a behavioural model of the operand-entry rules.

module tb_calc_sequencer;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] DataIn;
    logic [3:0] OpIn;
    logic       Enter, Clear, ChainMode;
    logic       AluStart;
    logic [7:0] AluA, AluB;
    logic [3:0] AluOp;
    logic       AluDone;
    logic [7:0] AluResult;
    logic [2:0] AluFlags;
    logic [7:0] Result;
    logic [2:0] Flags;
    logic [3:0] Stage;
    logic [7:0] OpCount;
    logic       Error;
    logic [2:0] DbgState;

    calc_sequencer dut (
        .clock(clock), .reset(reset), .DataIn(DataIn), .OpIn(OpIn), .Enter(Enter),
        .Clear(Clear), .ChainMode(ChainMode), .AluStart(AluStart), .AluA(AluA), .AluB(AluB),
        .AluOp(AluOp), .AluDone(AluDone), .AluResult(AluResult), .AluFlags(AluFlags),
        .Result(Result), .Flags(Flags), .Stage(Stage), .OpCount(OpCount), .Error(Error),
        .DbgState(DbgState)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ALU model controls, written only by the main process
    int         alu_lat = 3;
    logic       alu_override = 1'b0;
    logic [7:0] alu_ovr_val = 8'h00;
    int         inject_cnt = 0;
    // start monitor, written only by the ALU process
    int         start_cnt;
    logic [7:0] st_a, st_b;
    logic [3:0] st_op;

    // behavioural model: phase 0 idle, 1 have A, 2 have B, 3 exec, 4 result, 5 error
    int         m_phase;
    logic [7:0] m_a, m_b, m_res;
    logic [3:0] m_op;
    logic [2:0] m_flags;
    int         m_count;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        int         lat;
        logic [7:0] exp_res;
        logic [2:0] exp_flags;
    } vec_t;
    vec_t vecs[7];

    // op 1 add, 2 subtract (carry = borrow), 3 and, otherwise xor; flags {carry, overflow, zero}
    function automatic logic [10:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int ai, bi, r;
        logic [7:0] res;
        logic c, v;
        ai = int'(a);
        bi = int'(b);
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd1: begin
                r = ai + bi;
                res = 8'(r);
                c = (r > 255);
                v = (a[7] == b[7]) && (res[7] != a[7]);
            end
            4'd2: begin
                r = ai - bi;
                res = 8'(r);
                c = (ai < bi);
                v = (a[7] != b[7]) && (res[7] != a[7]);
            end
            4'd3: res = a & b;
            default: res = a ^ b;
        endcase
        return {c, v, (res == 8'h00), res};
    endfunction

    function automatic logic [3:0] stage_of(input int ph);
        case (ph)
            0: return 4'b0001;
            1: return 4'b0011;
            2, 3: return 4'b0111;
            4: return 4'b1111;
            default: return 4'b1001;
        endcase
    endfunction

    // external ALU: sees starts and answers alu_lat cycles later; inject_cnt forces a stray done
    initial begin
        int pending;
        int seen;
        logic fire;
        logic [10:0] r;
        pending = 0;
        seen = 0;
        start_cnt = 0;
        st_a = '0;
        st_b = '0;
        st_op = '0;
        AluDone = 1'b0;
        AluResult = '0;
        AluFlags = '0;
        forever begin
            @(posedge clock);
            #2;
            AluDone = 1'b0;
            fire = 1'b0;
            if (pending > 0) begin
                pending = pending - 1;
                fire = (pending == 0);
            end
            if (inject_cnt != seen) begin
                seen = inject_cnt;
                fire = 1'b1;
            end
            if (fire) begin
                r = ref_alu(st_a, st_b, st_op);
                AluDone = 1'b1;
                AluResult = alu_override ? alu_ovr_val : r[7:0];
                AluFlags = r[10:8];
            end
            if (AluStart) begin
                start_cnt++;
                st_a = AluA;
                st_b = AluB;
                st_op = AluOp;
                pending = alu_lat;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish within budget");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".stage"},  32'(Stage),   32'(stage_of(m_phase)));
        check({tag, ".alu_a"},  32'(AluA),    32'(m_a));
        check({tag, ".alu_b"},  32'(AluB),    32'(m_b));
        check({tag, ".alu_op"}, 32'(AluOp),   32'(m_op));
        check({tag, ".result"}, 32'(Result),  32'(m_res));
        check({tag, ".flags"},  32'(Flags),   32'(m_flags));
        check({tag, ".count"},  32'(OpCount), 32'(m_count));
        check({tag, ".error"},  32'(Error),   32'(m_phase == 5));
    endtask

    task automatic enter_model(input logic [7:0] d, input logic [3:0] op);
        case (m_phase)
            0: begin m_a = d; m_phase = 1; end
            1: begin m_b = d; m_phase = 2; end
            2: begin m_op = op; m_phase = 3; end
            4: begin m_a = ChainMode ? m_res : d; m_phase = 1; end
            default: ;
        endcase
    endtask

    task automatic clear_model();
        m_phase = 0;
        m_a = '0;
        m_b = '0;
        m_op = '0;
        m_res = '0;
        m_flags = '0;
    endtask

    task automatic press(input logic [7:0] d, input logic [3:0] op);
        DataIn = d;
        OpIn = op;
        Enter = 1'b1;
        repeat (DEB + 3) step();
        Enter = 1'b0;
        repeat (4) step();
        enter_model(d, op);
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        repeat (3) step();
        Clear = 1'b0;
        repeat (3) step();
        clear_model();
    endtask

    task automatic wait_result(input string tag);
        logic [10:0] r;
        int n;
        n = 0;
        while (Stage !== 4'b1111 && n < 100) begin
            step();
            n++;
        end
        check({tag, ".done_wait"}, 32'(n < 100), 32'd1);
        r = ref_alu(m_a, m_b, m_op);
        m_res = r[7:0];
        m_flags = r[10:8];
        if (m_count < 255) m_count++;
        m_phase = 4;
    endtask

    // launch from HAVE_B, then raise Clear in the AluStart cycle; done arrives alu_lat cycles after start
    task automatic launch_then_clear(input string tag, input logic [3:0] op);
        OpIn = op;
        Enter = 1'b1;
        repeat (DEB + 3) step();
        check({tag, ".start_seen"}, 32'(AluStart), 32'd1);
        Enter = 1'b0;
        Clear = 1'b1;
        repeat (3) step();
        Clear = 1'b0;
        repeat (6) step();
        clear_model();
    endtask

    initial begin
        int s0;
        logic [7:0] d;
        logic [3:0] op;

        vecs[0] = '{8'd25,  8'd17,  4'd1, 3, 8'd42,  3'b000};
        vecs[1] = '{8'd200, 8'd100, 4'd1, 2, 8'h2C,  3'b100};
        vecs[2] = '{8'd100, 8'd100, 4'd1, 1, 8'hC8,  3'b010};
        vecs[3] = '{8'd5,   8'd5,   4'd2, 4, 8'h00,  3'b001};
        vecs[4] = '{8'hF0,  8'h3C,  4'd3, 5, 8'h30,  3'b000};
        vecs[5] = '{8'h10,  8'h20,  4'd2, 1, 8'hF0,  3'b100};
        vecs[6] = '{8'h80,  8'h80,  4'd1, 6, 8'h00,  3'b111};

        reset = 1'b1;
        DataIn = '0;
        OpIn = '0;
        Enter = 1'b0;
        Clear = 1'b0;
        ChainMode = 1'b0;
        m_count = 0;
        clear_model();
        repeat (3) step();
        check_all("reset");
        check("reset.start", 32'(AluStart), 32'd0);
        reset = 1'b0;
        step();

        // 2-cycle press is shorter than the debounce window
        DataIn = 8'h55;
        Enter = 1'b1;
        repeat (2) step();
        Enter = 1'b0;
        repeat (8) step();
        check_all("short_press");

        for (int i = 0; i < 7; i++) begin
            press(vecs[i].a, 4'd0);
            check_all("vec.a");
            press(vecs[i].b, 4'd0);
            check_all("vec.b");
            s0 = start_cnt;
            alu_lat = vecs[i].lat;
            press(8'd0, vecs[i].op);
            wait_result("vec");
            check("vec.start_cycles", 32'(start_cnt - s0), 32'd1);
            check("vec.start_a", 32'(st_a), 32'(vecs[i].a));
            check("vec.start_b", 32'(st_b), 32'(vecs[i].b));
            check("vec.start_op", 32'(st_op), 32'(vecs[i].op));
            check("vec.exp_result", 32'(Result), 32'(vecs[i].exp_res));
            check("vec.exp_flags", 32'(Flags), 32'(vecs[i].exp_flags));
            check_all("vec.done");
            do_clear();
            check_all("vec.clear");
        end

        // chained accumulation: 25+17=42, then A<=42 ignoring DataIn=99, 42+8=50
        alu_lat = 3;
        press(8'd25, 4'd0);
        press(8'd17, 4'd0);
        press(8'd0, 4'd1);
        wait_result("chain1");
        check("chain1.result", 32'(Result), 32'd42);
        ChainMode = 1'b1;
        press(8'd99, 4'd0);
        check("chain.alu_a", 32'(AluA), 32'd42);
        check_all("chain.have_a");
        ChainMode = 1'b0;
        press(8'd8, 4'd0);
        press(8'd0, 4'd1);
        wait_result("chain2");
        check("chain2.result", 32'(Result), 32'd50);
        check_all("chain2");

        // Enter in EXEC is dropped
        press(8'd10, 4'd0);
        press(8'd3, 4'd0);
        s0 = start_cnt;
        alu_lat = 30;
        press(8'd0, 4'd1);
        press(8'd77, 4'd2);
        check_all("exec_enter");
        wait_result("exec_enter");
        check("exec_enter.start_cycles", 32'(start_cnt - s0), 32'd1);
        check_all("exec_enter.done");

        // stray done outside EXEC
        alu_override = 1'b1;
        alu_ovr_val = 8'hAA;
        inject_cnt++;
        repeat (3) step();
        check_all("stray_done_result");
        do_clear();
        inject_cnt++;
        repeat (3) step();
        check_all("stray_done_idle");

        // Clear in EXEC, done (value 7) arrives 2 cycles after the clear pulse
        alu_ovr_val = 8'd7;
        press(8'd1, 4'd0);
        press(8'd2, 4'd0);
        alu_lat = 4;
        launch_then_clear("abort_late", 4'd1);
        check_all("abort_late");
        // done in the very cycle of the clear pulse
        press(8'd1, 4'd0);
        press(8'd2, 4'd0);
        alu_lat = 2;
        launch_then_clear("abort_same", 4'd1);
        check_all("abort_same");
        alu_override = 1'b0;

        // Enter and Clear pulses coincide in HAVE_B
        press(8'd4, 4'd0);
        press(8'd5, 4'd0);
        s0 = start_cnt;
        OpIn = 4'd1;
        Enter = 1'b1;
        repeat (DEB) step();
        Clear = 1'b1;
        repeat (3) step();
        Enter = 1'b0;
        Clear = 1'b0;
        repeat (6) step();
        clear_model();
        check("enter_clear.no_start", 32'(start_cnt - s0), 32'd0);
        check_all("enter_clear");

        // randomized operations against the model
        for (int it = 0; it < 25; it++) begin
            ChainMode = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            press(d, 4'd0);
            check_all("rnd.a");
            d = 8'($urandom);
            press(d, 4'd0);
            check_all("rnd.b");
            op = 4'($urandom_range(1, 4));
            if ($urandom_range(0, 4) == 0) begin
                alu_lat = $urandom_range(2, 6);
                launch_then_clear("rnd.abort", op);
            end else begin
                alu_lat = $urandom_range(1, 6);
                press(8'd0, op);
                wait_result("rnd");
            end
            check_all("rnd.end");
        end

`ifdef CALC_TIMEOUT_EN
        do_clear();
        press(8'd1, 4'd0);
        press(8'd2, 4'd0);
        alu_lat = 0;
        press(8'd0, 4'd1);
        repeat (59) step();
        check_all("timeout.last_exec");
        step();
        m_phase = 5;
        check_all("timeout.error");
        press(8'd9, 4'd0);
        check_all("timeout.enter_ignored");
        alu_override = 1'b1;
        alu_ovr_val = 8'h5A;
        inject_cnt++;
        repeat (3) step();
        alu_override = 1'b0;
        check_all("timeout.done_ignored");
        do_clear();
        check_all("timeout.cleared");
`endif

        // only reset clears the operation counter
        reset = 1'b1;
        step();
        m_count = 0;
        clear_model();
        check_all("final_reset");
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
